// File: rtl/usr_pkg.sv
// Shared types and constants for the universal shift register.
package usr_pkg;

  typedef enum logic [1:0] {
    USR_HOLD = 2'b00,
    USR_SHR  = 2'b01,
    USR_SHL  = 2'b10,
    USR_LOAD = 2'b11
  } usr_mode_e;

  localparam logic USR_RST_VAL = '0;

endpackage

// File: rtl/usr_bit_cell.sv
// One register bit: 4:1 mux (hold / left neighbour / right neighbour / load) feeding a flop.
import usr_pkg::*;

module usr_bit_cell (
  input  logic      clk,
  input  logic      rst,
  input  usr_mode_e mode,
  input  logic      hold_bit,
  input  logic      left_bit,
  input  logic      right_bit,
  input  logic      load_bit,
  output logic      q
);

  logic d;

  // Any code outside HOLD/SHR/SHL falls through to LOAD.
  always_comb begin
    d = load_bit;
    case (mode)
      USR_HOLD: d = hold_bit;
      USR_SHR:  d = left_bit;
      USR_SHL:  d = right_bit;
      default:  d = load_bit;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= USR_RST_VAL;
    else     q <= d;
  end

endmodule

// File: rtl/universal_shift_reg.sv
// N-bit universal shift register: hold, shift-right, shift-left, parallel load.
// Define USR_SERIAL_OUT_EN to expose the so_r / so_l serial-out ports.
import usr_pkg::*;

module universal_shift_reg #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         data,
  input  logic         s0,
  input  logic         s1,
  input  logic [N-1:0] wData,
`ifdef USR_SERIAL_OUT_EN
  output logic         so_r,
  output logic         so_l,
`endif
  output logic [N-1:0] q
);

  usr_mode_e mode;
  assign mode = usr_mode_e'({s0, s1});

  // Left neighbour is the next-higher bit (source on SHR); right is next-lower (source on SHL).
  for (genvar i = 0; i < N; i++) begin : g_bit
    logic left_bit;
    logic right_bit;

    if (i == N - 1) begin : g_msb
      assign left_bit = data;
    end else begin : g_left
      assign left_bit = q[i+1];
    end

    if (i == 0) begin : g_lsb
      assign right_bit = data;
    end else begin : g_right
      assign right_bit = q[i-1];
    end

    usr_bit_cell u_cell (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .hold_bit  (q[i]),
      .left_bit  (left_bit),
      .right_bit (right_bit),
      .load_bit  (wData[i]),
      .q         (q[i])
    );
  end

`ifdef USR_SERIAL_OUT_EN
  assign so_r = q[0];
  assign so_l = q[N-1];
`endif

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed self-checking bench for universal_shift_reg (N=4).
// Serial-out checks are compiled in when USR_SERIAL_OUT_EN is defined.
module tb_universal_shift_reg;

  logic       clk;
  logic       rst;
  logic       data;
  logic       s0;
  logic       s1;
  logic [3:0] wData;
  logic [3:0] q;
`ifdef USR_SERIAL_OUT_EN
  logic       so_r;
  logic       so_l;
`endif

  int checks = 0;
  int errors = 0;

  universal_shift_reg #(.N(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .data  (data),
    .s0    (s0),
    .s1    (s1),
    .wData (wData),
`ifdef USR_SERIAL_OUT_EN
    .so_r  (so_r),
    .so_l  (so_l),
`endif
    .q     (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [1:0] modes [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    rst = 1'b1; data = 1'b1; wData = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      {s0, s1} = modes[i];
      data = ~data;
      #2;
      checks++;
      if (q !== 4'b0000) begin
        errors++;
        $display("FAIL reset_mid[%0d]: q=%b expected 0000", i, q);
      end
      tick();
      checks++;
      if (q !== 4'b0000) begin
        errors++;
        $display("FAIL reset_edge[%0d]: q=%b expected 0000", i, q);
      end
    end
    rst = 1'b0;
    {s0, s1} = 2'b11; wData = 4'b1111;
    tick();
    checks++;
    if (q !== 4'b1111) begin
      errors++;
      $display("FAIL reset_preload: q=%b expected 1111", q);
    end
    {s0, s1} = 2'b00;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (q !== 4'b0000) begin
      errors++;
      $display("FAIL reset_async: q=%b expected 0000", q);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (q !== 4'b0000) begin
      errors++;
      $display("FAIL reset_after_release: q=%b expected 0000", q);
    end
  endtask

  task automatic test_shift_right();
    logic       din [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] exp [4] = '{4'b1000, 4'b0100, 4'b1010, 4'b1101};
    {s0, s1} = 2'b01; wData = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      data = din[i];
      tick();
      checks++;
      if (q !== exp[i]) begin
        errors++;
        $display("FAIL shr[%0d]: q=%b expected %b", i, q, exp[i]);
      end
`ifdef USR_SERIAL_OUT_EN
      checks++;
      if (so_r !== exp[i][0]) begin
        errors++;
        $display("FAIL shr_so_r[%0d]: so_r=%b expected %b", i, so_r, exp[i][0]);
      end
`endif
    end
  endtask

  task automatic test_shift_left();
    logic [3:0] exp [3] = '{4'b1011, 4'b0111, 4'b1111};
    {s0, s1} = 2'b10; data = 1'b1; wData = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (q !== exp[i]) begin
        errors++;
        $display("FAIL shl[%0d]: q=%b expected %b", i, q, exp[i]);
      end
`ifdef USR_SERIAL_OUT_EN
      checks++;
      if (so_l !== exp[i][3]) begin
        errors++;
        $display("FAIL shl_so_l[%0d]: so_l=%b expected %b", i, so_l, exp[i][3]);
      end
`endif
    end
  endtask

  task automatic test_load();
    logic [3:0] words [3] = '{4'b1111, 4'b0110, 4'b1001};
    logic [3:0] finals[3] = '{4'b1111, 4'b0110, 4'b1001};
    {s0, s1} = 2'b11;
    // Use a sequence that ends at 0110 for the hold test by reloading at the end.
    for (int i = 0; i < 3; i++) begin
      wData = words[i];
      data = i[0];
      tick();
      checks++;
      if (q !== finals[i]) begin
        errors++;
        $display("FAIL load[%0d]: q=%b expected %b", i, q, finals[i]);
      end
    end
    wData = 4'b0110;
    tick();
    checks++;
    if (q !== 4'b0110) begin
      errors++;
      $display("FAIL load_0110: q=%b expected 0110", q);
    end
  endtask

  task automatic test_hold();
    {s0, s1} = 2'b00;
    for (int i = 0; i < 5; i++) begin
      data  = ~data;
      wData = ~wData;
      tick();
      checks++;
      if (q !== 4'b0110) begin
        errors++;
        $display("FAIL hold[%0d]: q=%b expected 0110", i, q);
      end
    end
  endtask

  task automatic test_reset_midshift();
    logic [3:0] exp [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    {s0, s1} = 2'b11; wData = 4'b1111;
    tick();
    {s0, s1} = 2'b01; data = 1'b0;
    tick();
    checks++;
    if (q !== 4'b0111) begin
      errors++;
      $display("FAIL midshift_shr: q=%b expected 0111", q);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (q !== 4'b0000) begin
      errors++;
      $display("FAIL midshift_async: q=%b expected 0000", q);
    end
    rst = 1'b0;
    {s0, s1} = 2'b10; data = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (q !== exp[i]) begin
        errors++;
        $display("FAIL midshift_shl[%0d]: q=%b expected %b", i, q, exp[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; data = 1'b0; s0 = 1'b0; s1 = 1'b0; wData = 4'b0000;
    #1;
    test_reset();
    test_shift_right();
    test_shift_left();
    test_load();
    test_hold();
    test_reset_midshift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
